// File: rtl/em_stage_reg.sv
// E->M pipeline register with E-stage exception resolution (Ov, AdEL, AdES).
// Optional feature macro: MMIO_RANGE_CHECK_EN adds address-window and timer-access checks.
module em_stage_reg #(
  parameter logic [31:0] EXC_PC   = 32'h0000_4180
`ifdef MMIO_RANGE_CHECK_EN
  , parameter logic [31:0] DM_TOP   = 32'h0000_2FFF
  , parameter logic [31:0] TC0_BASE = 32'h0000_7F00
  , parameter logic [31:0] TC1_BASE = 32'h0000_7F10
  , parameter logic [31:0] IG_BASE  = 32'h0000_7F20
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        req,
  input  logic [31:0] E_PC,
  input  logic [31:0] E_Instr,
  input  logic [31:0] E_AO,
  input  logic        E_overflow,
  input  logic        E_ov_chk,
  input  logic [31:0] E_RD2,
  input  logic [4:0]  E_A3,
  input  logic [3:0]  E_mem_op,
  input  logic [4:0]  E_ExcCode,
  input  logic        E_BD,
  output logic [31:0] M_PC,
  output logic [31:0] M_Instr,
  output logic [31:0] M_AO,
  output logic [31:0] M_RD2,
  output logic [4:0]  M_A3,
  output logic [3:0]  M_mem_op,
  output logic [4:0]  M_ExcCode,
  output logic        M_BD
);

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_OV   = 5'd12;

  logic        is_load_s, is_store_s, misalign_s, range_bad_s, new_exc_s;
  logic [4:0]  exc_s;

  logic [31:0] pc_q, instr_q, ao_q, rd2_q, pc_d, instr_d, ao_d, rd2_d;
  logic [4:0]  a3_q, exc_q, a3_d, exc_d;
  logic [3:0]  mem_op_q, mem_op_d;
  logic        bd_q, bd_d;

  // Classify the access and flag alignment / address-window violations.
  always_comb begin
    is_load_s  = (E_mem_op >= 4'd1) && (E_mem_op <= 4'd5);
    is_store_s = (E_mem_op >= 4'd6) && (E_mem_op <= 4'd8);
    misalign_s = (((E_mem_op == 4'd1) || (E_mem_op == 4'd6)) && (E_AO[1:0] != 2'b00)) ||
                 (((E_mem_op == 4'd2) || (E_mem_op == 4'd3) || (E_mem_op == 4'd7)) && E_AO[0]);
`ifdef MMIO_RANGE_CHECK_EN
    range_bad_s =
      !((E_AO <= DM_TOP) ||
        ((E_AO >= TC0_BASE) && (E_AO <= TC0_BASE + 32'h0000_000B)) ||
        ((E_AO >= TC1_BASE) && (E_AO <= TC1_BASE + 32'h0000_000B)) ||
        ((E_AO >= IG_BASE)  && (E_AO <= IG_BASE  + 32'h0000_0003))) ||
      ((((E_AO >= TC0_BASE) && (E_AO <= TC0_BASE + 32'h0000_000B)) ||
        ((E_AO >= TC1_BASE) && (E_AO <= TC1_BASE + 32'h0000_000B))) &&
       (E_mem_op != 4'd1) && (E_mem_op != 4'd6)) ||
      (is_store_s && ((E_AO == TC0_BASE + 32'h0000_0008) || (E_AO == TC1_BASE + 32'h0000_0008)));
`else
    range_bad_s = 1'b0;
`endif
  end

  // Earlier-stage codes win; only a freshly detected code kills the access.
  always_comb begin
    if (E_ExcCode != EXC_NONE) begin
      exc_s = E_ExcCode;
    end else if (E_ov_chk && E_overflow && (E_mem_op == 4'd0)) begin
      exc_s = EXC_OV;
    end else if (is_load_s && (E_overflow || misalign_s || range_bad_s)) begin
      exc_s = EXC_ADEL;
    end else if (is_store_s && (E_overflow || misalign_s || range_bad_s)) begin
      exc_s = EXC_ADES;
    end else begin
      exc_s = EXC_NONE;
    end
    new_exc_s = (E_ExcCode == EXC_NONE) && (exc_s != EXC_NONE);
  end

  // Next-state: flush bubble, load, or hold.
  always_comb begin
    pc_d     = pc_q;
    instr_d  = instr_q;
    ao_d     = ao_q;
    rd2_d    = rd2_q;
    a3_d     = a3_q;
    mem_op_d = mem_op_q;
    exc_d    = exc_q;
    bd_d     = bd_q;
    if (req) begin
      pc_d     = EXC_PC;
      instr_d  = 32'd0;
      ao_d     = 32'd0;
      rd2_d    = 32'd0;
      a3_d     = 5'd0;
      mem_op_d = 4'd0;
      exc_d    = EXC_NONE;
      bd_d     = 1'b0;
    end else if (en) begin
      pc_d     = E_PC;
      instr_d  = E_Instr;
      ao_d     = E_AO;
      rd2_d    = E_RD2;
      a3_d     = new_exc_s ? 5'd0 : E_A3;
      mem_op_d = new_exc_s ? 4'd0 : E_mem_op;
      exc_d    = exc_s;
      bd_d     = E_BD;
    end else begin
      pc_d     = pc_q;
    end
  end

  // Stage register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= 32'd0;
      instr_q  <= 32'd0;
      ao_q     <= 32'd0;
      rd2_q    <= 32'd0;
      a3_q     <= 5'd0;
      mem_op_q <= 4'd0;
      exc_q    <= 5'd0;
      bd_q     <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      ao_q     <= ao_d;
      rd2_q    <= rd2_d;
      a3_q     <= a3_d;
      mem_op_q <= mem_op_d;
      exc_q    <= exc_d;
      bd_q     <= bd_d;
    end
  end

  assign M_PC      = pc_q;
  assign M_Instr   = instr_q;
  assign M_AO      = ao_q;
  assign M_RD2     = rd2_q;
  assign M_A3      = a3_q;
  assign M_mem_op  = mem_op_q;
  assign M_ExcCode = exc_q;
  assign M_BD      = bd_q;

endmodule

// File: tb/tb_em_stage_reg.sv
// Directed table-driven bench for em_stage_reg; expectations follow MMIO_RANGE_CHECK_EN.
module tb_em_stage_reg;

`ifdef MMIO_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, en, req;
  logic [31:0] E_PC, E_Instr, E_AO, E_RD2;
  logic        E_overflow, E_ov_chk, E_BD;
  logic [4:0]  E_A3, E_ExcCode;
  logic [3:0]  E_mem_op;
  logic [31:0] M_PC, M_Instr, M_AO, M_RD2;
  logic [4:0]  M_A3, M_ExcCode;
  logic [3:0]  M_mem_op;
  logic        M_BD;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  em_stage_reg dut (
    .clk(clk), .reset(reset), .en(en), .req(req),
    .E_PC(E_PC), .E_Instr(E_Instr), .E_AO(E_AO), .E_overflow(E_overflow),
    .E_ov_chk(E_ov_chk), .E_RD2(E_RD2), .E_A3(E_A3), .E_mem_op(E_mem_op),
    .E_ExcCode(E_ExcCode), .E_BD(E_BD),
    .M_PC(M_PC), .M_Instr(M_Instr), .M_AO(M_AO), .M_RD2(M_RD2),
    .M_A3(M_A3), .M_mem_op(M_mem_op), .M_ExcCode(M_ExcCode), .M_BD(M_BD)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] ao;
    logic        ov;
    logic        ovc;
    logic [4:0]  a3;
    logic [4:0]  exc;
    logic [4:0]  x_exc;
    logic [4:0]  x_a3;
    logic [3:0]  x_op;
  } vec_t;

  localparam int N = 25;
  vec_t tbl [N];

  function automatic vec_t mk(input logic [3:0] op, input logic [31:0] ao, input logic ov,
                              input logic ovc, input logic [4:0] a3, input logic [4:0] exc,
                              input logic [4:0] x_exc);
    vec_t v;
    logic kill;
    kill    = (exc == 5'd0) && (x_exc != 5'd0);
    v.op    = op;
    v.ao    = ao;
    v.ov    = ov;
    v.ovc   = ovc;
    v.a3    = a3;
    v.exc   = exc;
    v.x_exc = x_exc;
    v.x_a3  = kill ? 5'd0 : a3;
    v.x_op  = kill ? 4'd0 : op;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                         input logic [31:0] ao, input logic [31:0] rd2, input logic [4:0] a3,
                         input logic [3:0] op, input logic [4:0] exc, input logic bd);
    chk({tag, ".pc"},    M_PC, pc);
    chk({tag, ".instr"}, M_Instr, instr);
    chk({tag, ".ao"},    M_AO, ao);
    chk({tag, ".rd2"},   M_RD2, rd2);
    chk({tag, ".a3"},    {27'd0, M_A3}, {27'd0, a3});
    chk({tag, ".op"},    {28'd0, M_mem_op}, {28'd0, op});
    chk({tag, ".exc"},   {27'd0, M_ExcCode}, {27'd0, exc});
    chk({tag, ".bd"},    {31'd0, M_BD}, {31'd0, bd});
  endtask

  task automatic drive(input logic [31:0] pc, input logic [3:0] op, input logic [31:0] ao,
                       input logic ov, input logic ovc, input logic [4:0] a3,
                       input logic [4:0] exc, input logic bd);
    E_PC = pc; E_Instr = pc ^ 32'h8C00_0000; E_AO = ao; E_RD2 = ~ao;
    E_overflow = ov; E_ov_chk = ovc; E_A3 = a3; E_mem_op = op;
    E_ExcCode = exc; E_BD = bd;
  endtask

  initial begin
    tbl[0]  = mk(4'd1, 32'h0000_0102, 1'b0, 1'b0, 5'd3,  5'd0,  5'd4);
    tbl[1]  = mk(4'd0, 32'h0000_0000, 1'b1, 1'b1, 5'd8,  5'd0,  5'd12);
    tbl[2]  = mk(4'd0, 32'h0000_0000, 1'b1, 1'b1, 5'd8,  5'd10, 5'd10);
    tbl[3]  = mk(4'd6, 32'h0000_7F08, 1'b0, 1'b0, 5'd0,  5'd0,  RC ? 5'd5 : 5'd0);
    tbl[4]  = mk(4'd6, 32'h0000_7F04, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0);
    tbl[5]  = mk(4'd1, 32'h0000_3000, 1'b0, 1'b0, 5'd4,  5'd0,  RC ? 5'd4 : 5'd0);
    tbl[6]  = mk(4'd1, 32'h0000_2FFC, 1'b0, 1'b0, 5'd4,  5'd0,  5'd0);
    tbl[7]  = mk(4'd2, 32'h0000_0101, 1'b0, 1'b0, 5'd5,  5'd0,  5'd4);
    tbl[8]  = mk(4'd3, 32'h0000_0102, 1'b0, 1'b0, 5'd5,  5'd0,  5'd0);
    tbl[9]  = mk(4'd7, 32'h0000_0001, 1'b0, 1'b0, 5'd0,  5'd0,  5'd5);
    tbl[10] = mk(4'd8, 32'h0000_0013, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0);
    tbl[11] = mk(4'd4, 32'h0000_7F00, 1'b0, 1'b0, 5'd6,  5'd0,  RC ? 5'd4 : 5'd0);
    tbl[12] = mk(4'd6, 32'hFFFF_FFFC, 1'b0, 1'b0, 5'd0,  5'd0,  RC ? 5'd5 : 5'd0);
    tbl[13] = mk(4'd6, 32'h0000_0100, 1'b1, 1'b0, 5'd0,  5'd0,  5'd5);
    tbl[14] = mk(4'd5, 32'h0000_0100, 1'b1, 1'b0, 5'd7,  5'd0,  5'd4);
    tbl[15] = mk(4'd1, 32'h0000_7F24, 1'b0, 1'b0, 5'd2,  5'd0,  RC ? 5'd4 : 5'd0);
    tbl[16] = mk(4'd1, 32'h0000_7F20, 1'b0, 1'b0, 5'd2,  5'd0,  5'd0);
    tbl[17] = mk(4'd1, 32'h0000_0102, 1'b0, 1'b0, 5'd9,  5'd4,  5'd4);
    tbl[18] = mk(4'd1, 32'h0000_7F1C, 1'b0, 1'b0, 5'd2,  5'd0,  RC ? 5'd4 : 5'd0);
    tbl[19] = mk(4'd1, 32'h0000_7F18, 1'b0, 1'b0, 5'd2,  5'd0,  5'd0);
    tbl[20] = mk(4'd0, 32'h0000_0000, 1'b1, 1'b0, 5'd11, 5'd0,  5'd0);
    tbl[21] = mk(4'd6, 32'h0000_7F18, 1'b0, 1'b0, 5'd0,  5'd0,  RC ? 5'd5 : 5'd0);
    tbl[22] = mk(4'd5, 32'h0000_2FFF, 1'b0, 1'b0, 5'd3,  5'd0,  5'd0);
    tbl[23] = mk(4'd8, 32'h0000_3000, 1'b0, 1'b0, 5'd0,  5'd0,  RC ? 5'd5 : 5'd0);
    tbl[24] = mk(4'd6, 32'h0000_0100, 1'b1, 1'b1, 5'd0,  5'd0,  5'd5);

    // Reset with every input nonzero.
    reset = 1'b1; en = 1'b1; req = 1'b1;
    drive(32'hFFFF_FFFF, 4'd6, 32'h1234_5679, 1'b1, 1'b1, 5'd31, 5'd7, 1'b1);
    @(posedge clk); #1;
    chk_all("reset", 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 4'd0, 5'd0, 1'b0);
    reset = 1'b0; req = 1'b0;

    for (int i = 0; i < N; i++) begin
      drive(32'h0000_3000 + 32'(i * 4), tbl[i].op, tbl[i].ao, tbl[i].ov, tbl[i].ovc,
            tbl[i].a3, tbl[i].exc, i[0]);
      @(posedge clk); #1;
      chk_all($sformatf("vec%0d", i), 32'h0000_3000 + 32'(i * 4),
              (32'h0000_3000 + 32'(i * 4)) ^ 32'h8C00_0000, tbl[i].ao, ~tbl[i].ao,
              tbl[i].x_a3, tbl[i].x_op, tbl[i].x_exc, i[0]);
    end

    // Stall: load a misaligned lw, then hold while inputs change.
    drive(32'h0000_3500, 4'd1, 32'h0000_0102, 1'b0, 1'b0, 5'd3, 5'd0, 1'b1);
    @(posedge clk); #1;
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(32'h0000_3600 + 32'(k * 4), 4'd1, 32'h0000_0200, 1'b0, 1'b0, 5'd9, 5'd0, 1'b0);
      @(posedge clk); #1;
      chk_all($sformatf("hold%0d", k), 32'h0000_3500, 32'h0000_3500 ^ 32'h8C00_0000,
              32'h0000_0102, ~32'h0000_0102, 5'd0, 4'd0, 5'd4, 1'b1);
    end

    // Flush while stalled.
    req = 1'b1;
    @(posedge clk); #1;
    chk_all("req", 32'h0000_4180, 32'd0, 32'd0, 32'd0, 5'd0, 4'd0, 5'd0, 1'b0);

    // Reset outranks a concurrent flush.
    reset = 1'b1; en = 1'b1;
    @(posedge clk); #1;
    chk_all("rst_req", 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 4'd0, 5'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
